// File: rtl/prbs_pkg.sv
// Shared definitions for the 4-bit PRBS (x^4+x+1, period 15) generator and checker.
package prbs_pkg;

  // Checker operating modes; the encoding is visible on the checker's debug state port.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  // Feedback taps within the 4-bit history window (h[3] oldest, h[0] newest).
  localparam int TAP_HI = 3;
  localparam int TAP_LO = 2;

  // Sequence period of the maximal-length 4-bit LFSR.
  localparam int PRBS4_LEN = 15;

  // Next expected bit: s[n+4] = s[n+1] ^ s[n].
  function automatic logic prbs4_pred(input logic [3:0] h);
    return h[TAP_HI] ^ h[TAP_LO];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  // Clear first, otherwise count up and stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/prbs4_checker.sv
// Serial PRBS4 checker: self-synchronises to the received stream, locks after a run
// of correct predictions, then flywheels on its own sequence and counts bit errors.
//
// Input handshake: din_valid qualifies din on each rising edge. There is no ready;
// the checker accepts one bit on every edge where din_valid is high, back to back,
// and nothing inside it advances on an edge where din_valid is low.
module prbs4_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_ERRS = 3,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output prbs_state_t      state
);

  localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_ERRS);

  logic [3:0] h;          // history window, h[0] newest
  logic [1:0] fill_cnt;   // bits shifted in while in FILL
  logic [3:0] match_cnt;  // consecutive correct predictions in SEARCH
  logic [3:0] miss_cnt;   // consecutive mismatches in LOCKED
  logic       pred;
  logic       mismatch;
  logic       count_err;

  assign pred      = prbs4_pred(h);
  assign mismatch  = din ^ pred;
  assign count_err = din_valid && (state == LOCKED) && mismatch;

  // Mode sequencing, history update and the lock/unlock run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      h         <= 4'b0000;
      fill_cnt  <= 2'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= count_err;
      if (din_valid) begin
        case (state)
          FILL: begin
            h <= {h[2:0], din};
            if (fill_cnt == 2'd3) begin
              state     <= SEARCH;
              fill_cnt  <= 2'd0;
              match_cnt <= 4'd0;
            end else begin
              fill_cnt <= fill_cnt + 2'd1;
            end
          end
          SEARCH: begin
            h <= {h[2:0], din};
            // An all-zero window predicts zero forever, so it never counts as a match.
            if ((h != 4'b0000) && !mismatch) begin
              if (match_cnt + 4'd1 == LOCK_TGT) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= 4'd0;
                miss_cnt  <= 4'd0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              match_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            // Flywheel: the window follows our own prediction, so a corrupted
            // received bit cannot disturb later predictions.
            h <= {h[2:0], pred};
            if (mismatch) begin
              if (miss_cnt + 4'd1 == UNLOCK_TGT) begin
                state    <= FILL;
                locked   <= 1'b0;
                fill_cnt <= 2'd0;
                miss_cnt <= 4'd0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end else begin
              miss_cnt <= 4'd0;
            end
          end
          default: begin
            state  <= FILL;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk(clk),
    .rst(rst),
    .inc(count_err),
    .clr(clr_err),
    .cnt(err_cnt)
  );

endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: a step table with hand-computed end states, hand-written
// corner sequences, and randomized traffic, all checked cycle by cycle against a
// queue-based model of the checker's rules.
module tb_prbs4_checker;
  import prbs_pkg::*;

  localparam int LOCK_CNT    = 8;
  localparam int UNLOCK_ERRS = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic clr_err = 1'b0;

  always #5 clk = ~clk;

  logic        locked, err_pulse, locked2, err_pulse2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;
  prbs_state_t state, state2;

  prbs4_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state)
  );

  prbs4_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERRS(UNLOCK_ERRS), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr_err(clr_err),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .state(state2)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- generator: one period of the reference sequence ----------------
  bit ref_seq[PRBS4_LEN] = '{0,0,0,1,0,0,1,1,0,1,0,1,1,1,1};
  int gen_idx = 0;

  function automatic bit next_bit();
    bit b;
    b = ref_seq[gen_idx % PRBS4_LEN];
    gen_idx++;
    return b;
  endfunction

  // ---------------- reference model ----------------
  localparam int M_FILL = 0, M_SEARCH = 1, M_LOCKED = 2;
  int m_mode, m_fill, m_run, m_miss, m_err;
  bit win[$];          // last four bits, oldest first
  bit exp_pulse;

  task automatic model_reset();
    m_mode = M_FILL; m_fill = 0; m_run = 0; m_miss = 0; m_err = 0;
    win = '{0, 0, 0, 0};
    exp_pulse = 0;
  endtask

  task automatic model_valid(input bit b);
    bit p, nz;
    p  = win[0] ^ win[1];
    nz = win[0] | win[1] | win[2] | win[3];
    exp_pulse = 0;
    if (m_mode == M_LOCKED) begin
      win.push_back(p);
      void'(win.pop_front());
      if (b != p) begin
        exp_pulse = 1;
        m_err++;
        m_miss++;
        if (m_miss == UNLOCK_ERRS) begin
          m_mode = M_FILL;
          m_fill = 0;
        end
      end else begin
        m_miss = 0;
      end
    end else begin
      win.push_back(b);
      void'(win.pop_front());
      if (m_mode == M_FILL) begin
        m_fill++;
        if (m_fill == 4) begin
          m_mode = M_SEARCH;
          m_run  = 0;
        end
      end else begin
        m_run = (nz && (b == p)) ? m_run + 1 : 0;
        if (m_run == LOCK_CNT) begin
          m_mode = M_LOCKED;
          m_miss = 0;
        end
      end
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_outputs();
    chk("locked",     int'(locked),     int'(m_mode == M_LOCKED));
    chk("err_pulse",  int'(err_pulse),  int'(exp_pulse));
    chk("err_cnt",    int'(err_cnt),    sat(m_err, 255));
    chk("locked_w2",  int'(locked2),    int'(m_mode == M_LOCKED));
    chk("err_cnt_w2", int'(err_cnt2),   sat(m_err, 3));
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit v, input bit b, input bit c);
    @(negedge clk);
    din_valid = v;
    din       = b;
    clr_err   = c;
    @(posedge clk);
    if (v) model_valid(b);
    else   exp_pulse = 0;
    if (c) m_err = 0;
    #1;
    check_outputs();
  endtask

  // Reset pulse placed between clock edges; outputs must clear without an edge.
  task automatic reset_between_edges();
    @(negedge clk);
    din_valid = 0; din = 0; clr_err = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_locked",    int'(locked),    0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_err_cnt",   int'(err_cnt),   0);
    chk("rst_err_cnt2",  int'(err_cnt2),  0);
    #1 rst = 1'b0;
  endtask

  // ---------------- step table ----------------
  localparam int K_CLEAN = 0, K_FLIP = 1, K_CLR = 2;
  typedef struct {
    int kind;
    int count;
    bit exp_locked;
    int exp_err;
  } step_t;

  step_t steps[$];

  task automatic run_step(input step_t s);
    for (int i = 0; i < s.count; i++) begin
      case (s.kind)
        K_CLEAN: cyc(1'b1, next_bit(), 1'b0);
        K_FLIP:  cyc(1'b1, ~next_bit(), 1'b0);
        default: cyc(1'b0, 1'b0, 1'b1);
      endcase
    end
    chk("step_locked",  int'(locked),   int'(s.exp_locked));
    chk("step_err_cnt", int'(err_cnt),  s.exp_err);
    chk("step_err_w2",  int'(err_cnt2), sat(s.exp_err, 3));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    bit got_lock;
    int flips;

    model_reset();
    steps = '{
      '{K_CLEAN, 11, 0, 0},   // fill + 7 matches: not yet locked
      '{K_CLEAN,  1, 1, 0},   // 12th valid bit locks
      '{K_CLEAN, 20, 1, 0},
      '{K_FLIP,   1, 1, 1},   // single error, lock held
      '{K_CLEAN,  6, 1, 1},
      '{K_CLR,    1, 1, 0},
      '{K_FLIP,   1, 1, 1},
      '{K_CLEAN,  2, 1, 1},
      '{K_FLIP,   1, 1, 2},
      '{K_CLEAN,  2, 1, 2},
      '{K_FLIP,   1, 1, 3},   // three separated flips
      '{K_CLEAN,  4, 1, 3},
      '{K_FLIP,   2, 1, 5},
      '{K_FLIP,   1, 0, 6},   // third consecutive miss drops lock, still counted
      '{K_CLEAN, 11, 0, 6},
      '{K_CLEAN,  1, 1, 6},   // relock after 12 clean bits
      '{K_CLEAN, 10, 1, 6}
    };

    // Reset values while rst is held over edges.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_locked",    int'(locked),    0);
    chk("reset_err_pulse", int'(err_pulse), 0);
    chk("reset_err_cnt",   int'(err_cnt),   0);
    chk("reset_state",     int'(state == FILL), 1);
    @(negedge clk);
    rst = 1'b0;

    foreach (steps[i]) run_step(steps[i]);

    // Mid-stream reset while locked, then relock on exactly 12 clean bits.
    reset_between_edges();
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, next_bit(), 1'b0);
      chk("relock_point", int'(locked), int'(k >= 12));
    end

    // Valid on every other cycle: lock point counted in valid bits, idles change nothing.
    reset_between_edges();
    for (int k = 1; k <= 24; k++) begin
      cyc(1'b1, next_bit(), 1'b0);
      chk("gapped_lock", int'(locked), int'(k >= 12));
      cyc(1'b0, 1'b0, 1'b0);
      chk("gapped_idle", int'(locked), int'(k >= 12));
    end

    // All-zero stream never locks.
    reset_between_edges();
    for (int k = 0; k < 64; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("zero_no_lock", int'(locked), 0);
    end

    // Recover lock on a clean stream, bounded.
    got_lock = 0;
    for (int k = 0; k < 60 && !got_lock; k++) begin
      cyc(1'b1, next_bit(), 1'b0);
      got_lock = locked;
    end
    chk("relock_after_zeros", int'(got_lock), 1);

    // Every 4th bit wrong: 2-bit counter saturates at 3, lock holds.
    flips = 0;
    for (int k = 1; k <= 16; k++) begin
      if (k % 4 == 0) begin
        cyc(1'b1, ~next_bit(), 1'b0);
        flips++;
      end else begin
        cyc(1'b1, next_bit(), 1'b0);
      end
    end
    chk("sat_err_w2",    int'(err_cnt2), 3);
    chk("sat_err_w8",    int'(err_cnt),  flips);
    chk("sat_locked",    int'(locked),   1);

    // clr_err on the same edge as a counted error: count clears, pulse still fires.
    cyc(1'b1, ~next_bit(), 1'b1);
    chk("clr_vs_err_pulse", int'(err_pulse), 1);
    chk("clr_vs_err_cnt",   int'(err_cnt),   0);
    chk("clr_vs_err_w2",    int'(err_cnt2),  0);

    // Randomized traffic: light then bursty corruption, random gaps and clears.
    for (int k = 0; k < 1500; k++) begin
      bit v, f, c, b;
      v = ($urandom_range(0, 3) != 0);
      f = (k < 1000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 15) == 0);
      b = v ? next_bit() : 1'b0;
      cyc(v, v ? (b ^ f) : 1'b0, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs4_checker.md
# prbs4_checker

Serial PRBS checker for the 4-bit LFSR generator (x^4+x+1, period 15) that sits at the receive end of the same link. It self-synchronises to the incoming bit stream and declares lock after a run of correct predictions. Once locked, it flywheels on its own predicted sequence, so each corrupted bit is counted exactly once. It reports errors per bit and as a saturating count, and drops lock on a burst of consecutive errors.

## Interface
- LOCK_CNT, 8: number of consecutive correct predictions in SEARCH required to lock (1..15)
- UNLOCK_ERRS, 3: number of consecutive mismatches in LOCKED that drop lock (1..15)
- ERR_W, 8: width of the error counter

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  din is sampled on this edge
- din  in  1  received serial bit; the generator's out[3], oldest bit first
- clr_err  in  1  synchronous clear of err_cnt
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse: the bit just sampled mismatched while LOCKED
- err_cnt  out  ERR_W  saturating count of mismatches seen while LOCKED

## Operation
- History register h[3:0]: h[0] holds the newest bit and h[3] the oldest.
- Prediction: pred = h[3] ^ h[2]. This implements s[n+4] = s[n+1] ^ s[n].
- Reference sequence, one period starting from seed 0001: 0,0,0,1,0,0,1,1,0,1,0,1,1,1,1.
- Nothing advances on a cycle with din_valid=0. All state holds and err_pulse is 0.
- States:
  - FILL:
    - Each valid bit shifts din into h and increments fill_cnt.
    - When the 4th bit is shifted in, go to SEARCH with match_cnt=0.
  - SEARCH:
    - Each valid bit shifts din into h.
    - If h≠0000 before the shift and din==pred, increment match_cnt. Otherwise set match_cnt=0.
    - When match_cnt reaches LOCK_CNT, go to LOCKED with miss_cnt=0.
    - Mismatches in SEARCH are not counted in err_cnt.
  - LOCKED:
    - Each valid bit shifts pred (not din) into h. This is the flywheel.
    - If din≠pred: pulse err_pulse, increment err_cnt (saturating at 2^ERR_W−1), and increment miss_cnt.
    - If din==pred: set miss_cnt=0.
    - When miss_cnt reaches UNLOCK_ERRS, go to FILL with fill_cnt=0. h is not cleared.
- An all-zero input stream never locks.
- clr_err has priority. If clr_err coincides with a counted error, err_cnt becomes 0, but err_pulse still fires.

## Timing
- Reset values: locked=0, err_pulse=0, err_cnt=0, state=FILL, h=0000, all internal counters 0.
- All outputs are registered and change only on the clk edge that samples a valid bit (or the edge where clr_err is applied).
- locked:
  - Rises on the edge that samples the bit making match_cnt==LOCK_CNT. From reset with a clean stream, this is the edge sampling valid bit 4+LOCK_CNT.
  - Falls on the edge that samples the UNLOCK_ERRS-th consecutive mismatch.
- err_pulse is high for exactly the one cycle following the sampling edge of the erroneous bit.
  - This includes the bit that causes unlock; that bit is also counted.
- Back-to-back valid bits are supported at one bit per clock with no bubbles.
- Asserting rst mid-stream returns every output to its reset value immediately, independent of clk.

## Structure
- The shared package prbs_pkg holds:
  - the state enum {FILL, SEARCH, LOCKED}
  - the tap constants: feedback taps 3 and 2 of the history window
  - PRBS4_LEN = 15
- The generator's bench reuses the same package.
- One sub-module is natural: sat_counter (width parameter, inc, clr with priority, async rst), used for err_cnt.
- fill_cnt, match_cnt and miss_cnt stay inline.

## Test plan
1. Reset mid-stream while locked (rst pulse between edges) -> locked, err_pulse and err_cnt all go to 0 at once; relock requires 12 clean bits (defaults).
2. Clean stream, generator seeded 0001, 120 contiguous valid bits -> locked rises on the edge sampling bit 12; err_pulse never fires; err_cnt=0.
3. Clean stream with din_valid low on every other cycle -> same lock point counted in valid bits (12), with no extra state change on idle cycles.
4. Locked, then one flipped bit -> exactly one err_pulse, err_cnt=1, locked stays 1. Three flips separated by clean bits -> err_cnt=3, locked stays 1.
5. Locked, then three consecutive flipped bits -> err_cnt=3 and locked falls on the 3rd flip. Clean stream resumes -> locked returns after 12 more valid bits.
6. All-zero input for 64 valid bits -> locked stays 0. Then, with ERR_W=2, drive a stream that is wrong on every 4th bit while locked -> err_cnt saturates at 3. clr_err coinciding with an error -> err_cnt=0 and err_pulse=1.
